flag_branch_unit: RTL and testbench
===================================

FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 5, program counter width (32-entry instruction memory).
REQ-002 SHALL have parameter OFF_W, default 8, branch offset width, two's complement.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flags_in  input  4  ALU flags {C,Z,N,V}, bit 3 = carry, 2 = zero, 1 = negative, 0 = overflow.
REQ-006 SHALL have port flags_we  input  1  latch flags_in into flag register this cycle.
REQ-007 SHALL have port pc_en  input  1  advance PC this cycle; 0 = stall.
REQ-008 SHALL have port br_type  input  3  branch condition select, see REQ-013.
REQ-009 SHALL have port br_offset  input  OFF_W  signed offset relative to pc+1.
REQ-010 SHALL have port pc  output  PC_W  registered program counter.
REQ-011 SHALL have port flags_q  output  4  registered flags {C,Z,N,V}.
REQ-012 SHALL have port flush  output  1  registered; high for exactly one cycle after a taken branch.

Function
REQ-013 br_type decode SHALL be: 000 none; 001 JUMP (always); 010 BRE (Z); 011 BRNE (!Z); 100 BRG (!Z & (N==V)); 101 BRGE (N==V); 110 BRC (C); 111 BRN (N).
REQ-014 Condition SHALL be evaluated on flags_q (registered value), never on flags_in.
REQ-015 When flags_we=1 and a conditional branch occur in the same cycle, the branch SHALL use pre-update flags_q; new flags visible next cycle.
REQ-016 When pc_en=1 and condition true: pc <= pc + 1 + sign_extend(br_offset), truncated modulo 2^PC_W; flush <= 1.
REQ-017 When pc_en=1 and condition false or br_type=000: pc <= pc + 1 modulo 2^PC_W; flush <= 0.
REQ-018 When pc_en=0: pc holds, br_type ignored, flush <= 0; flags_we still honoured.
REQ-019 flags_q SHALL update only when flags_we=1, otherwise hold.
REQ-020 Latency: PC update and flush visible one cycle after the evaluating edge; no combinational path from inputs to outputs.
REQ-021 Wrap-around: pc = 2^PC_W-1 incrementing SHALL yield 0; negative offsets wrapping below 0 SHALL wrap modulo 2^PC_W.
REQ-022 Offset of -1 SHALL produce a self-loop (pc unchanged) with flush=1 each taken cycle.

Reset
REQ-023 reset=1 SHALL immediately force pc=0, flags_q=4'b0000, flush=0, independent of clk.
REQ-024 Reset asserted mid-stall or mid-branch SHALL discard the pending update; first post-reset edge with pc_en=1 evaluates against flags_q=0.

Configuration
REQ-025 Macro BRANCH_COUNT_EN SHALL, when defined, add output taken_count (8 bits): counts taken branches (including JUMP), saturates at 255, resets to 0, updates on the same edge as pc.
REQ-026 Without BRANCH_COUNT_EN the taken_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-027 Reset, then 3 edges pc_en=1, br_type=000 -> pc = 0,1,2,3; flush=0 throughout.
REQ-028 flags_we=1, flags_in=4'b0100 one cycle; next cycle pc=3, br_type=010, br_offset=+4 -> pc=8, flush=1 for one cycle only.
REQ-029 Same cycle flags_we=1 with flags_in Z=1 while flags_q Z=0, br_type=010 -> branch not taken, pc+1; following cycle BRE taken.
REQ-030 flags_q N=1,V=0: BRGE not taken, BRN taken; N=1,V=1,Z=0: BRG taken; pc=31, JUMP offset +0 -> pc=0 (wrap).
REQ-031 pc_en=0 with br_type=001 for 4 cycles -> pc holds, flush=0; assert reset asynchronously mid-cycle -> pc=0 before next edge.
REQ-032 With BRANCH_COUNT_EN: 260 consecutive taken JUMPs -> taken_count=255 saturated; reset -> 0.

Source files
------------

// File: rtl/flag_branch_unit_if.sv
// Bus between the flag/branch unit and its controller: flag writes, PC advance and branch select in; PC, flags and flush out.
// With BRANCH_COUNT_EN defined the bus also carries the saturating taken-branch count.
interface flag_branch_unit_if #(
  parameter int PC_W  = 5,
  parameter int OFF_W = 8
);
  logic [3:0]       flags_in;
  logic             flags_we;
  logic             pc_en;
  logic [2:0]       br_type;
  logic [OFF_W-1:0] br_offset;
  logic [PC_W-1:0]  pc;
  logic [3:0]       flags_q;
  logic             flush;
`ifdef BRANCH_COUNT_EN
  logic [7:0]       taken_count;
`endif

`ifdef BRANCH_COUNT_EN
  modport master (
    output flags_in, flags_we, pc_en, br_type, br_offset,
    input  pc, flags_q, flush, taken_count
  );
  modport slave (
    input  flags_in, flags_we, pc_en, br_type, br_offset,
    output pc, flags_q, flush, taken_count
  );
`else
  modport master (
    output flags_in, flags_we, pc_en, br_type, br_offset,
    input  pc, flags_q, flush
  );
  modport slave (
    input  flags_in, flags_we, pc_en, br_type, br_offset,
    output pc, flags_q, flush
  );
`endif
endinterface

// File: rtl/flag_branch_unit.sv
// Flag register plus conditional-branch program counter; branches test the registered flags only.
// Optional feature macro BRANCH_COUNT_EN adds an 8-bit saturating taken-branch counter.
module flag_branch_unit #(
  parameter int PC_W  = 5,
  parameter int OFF_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  flag_branch_unit_if.slave bus
);

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JUMP = 3'b001;
  localparam logic [2:0] BR_E    = 3'b010;
  localparam logic [2:0] BR_NE   = 3'b011;
  localparam logic [2:0] BR_G    = 3'b100;
  localparam logic [2:0] BR_GE   = 3'b101;
  localparam logic [2:0] BR_C    = 3'b110;
  localparam logic [2:0] BR_N    = 3'b111;

  // Flag layout is {C,Z,N,V}.
  function automatic logic branch_cond(input logic [2:0] sel, input logic [3:0] f);
    logic c, z, n, v;
    c = f[3];
    z = f[2];
    n = f[1];
    v = f[0];
    case (sel)
      BR_NONE: branch_cond = 1'b0;
      BR_JUMP: branch_cond = 1'b1;
      BR_E:    branch_cond = z;
      BR_NE:   branch_cond = ~z;
      BR_G:    branch_cond = ~z & (n == v);
      BR_GE:   branch_cond = (n == v);
      BR_C:    branch_cond = c;
      BR_N:    branch_cond = n;
      default: branch_cond = 1'b0;
    endcase
  endfunction

  logic [PC_W-1:0] pc_r;
  logic [3:0]      flags_r;
  logic            flush_r;
  logic [PC_W-1:0] off_adj_s;
  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] pc_next_s;
  logic            taken_s;

  // Offset reduced to PC width; only the low PC_W bits matter for modulo arithmetic.
  if (OFF_W >= PC_W) begin : g_off_trunc
    assign off_adj_s = bus.br_offset[PC_W-1:0];
  end else begin : g_off_sext
    assign off_adj_s = {{(PC_W-OFF_W){bus.br_offset[OFF_W-1]}}, bus.br_offset};
  end

  // Next-PC selection: stall, sequential, or taken branch.
  always_comb begin
    pc_inc_s  = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
    taken_s   = 1'b0;
    pc_next_s = pc_r;
    if (bus.pc_en) begin
      taken_s = branch_cond(bus.br_type, flags_r);
      if (taken_s) begin
        pc_next_s = pc_inc_s + off_adj_s;
      end else begin
        pc_next_s = pc_inc_s;
      end
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC, flush and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r    <= {PC_W{1'b0}};
      flags_r <= 4'b0000;
      flush_r <= 1'b0;
    end else begin
      pc_r    <= pc_next_s;
      flush_r <= taken_s;
      if (bus.flags_we) begin
        flags_r <= bus.flags_in;
      end else begin
        flags_r <= flags_r;
      end
    end
  end

  assign bus.pc      = pc_r;
  assign bus.flags_q = flags_r;
  assign bus.flush   = flush_r;

`ifdef BRANCH_COUNT_EN
  logic [7:0] count_r;

  // Taken-branch counter, sticks at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (taken_s && (count_r != 8'hFF)) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign bus.taken_count = count_r;
`endif

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: an integer-arithmetic model checked every cycle plus literal pins.
// Exercises the BRANCH_COUNT_EN counter when that macro is defined.
module tb_flag_branch_unit;

  localparam int PC_W  = 5;
  localparam int OFF_W = 8;
  localparam int PC_MOD = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Model state: plain integers, reasoning straight from the branch rules.
  int   m_pc;
  int   m_flags;
  int   m_flush;
  int   m_cnt;

  flag_branch_unit_if #(.PC_W(PC_W), .OFF_W(OFF_W)) bus ();

  flag_branch_unit #(.PC_W(PC_W), .OFF_W(OFF_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_true(input int bt, input int f);
    bit c, z, n, v;
    c = f[3];
    z = f[2];
    n = f[1];
    v = f[0];
    case (bt)
      1: return 1'b1;
      2: return z;
      3: return !z;
      4: return !z && (n == v);
      5: return n == v;
      6: return c;
      7: return n;
      default: return 1'b0;
    endcase
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("pc", int'(bus.pc), m_pc);
    chk("flags_q", int'(bus.flags_q), m_flags);
    chk("flush", int'(bus.flush), m_flush);
`ifdef BRANCH_COUNT_EN
    chk("taken_count", int'(bus.taken_count), m_cnt);
`endif
  end

  task automatic step(input bit en, input int bt, input int off, input bit fwe, input int fin);
    int  n_pc, n_flags, n_cnt;
    bit  taken;
    int  off_v;
    off_v          = off;
    bus.pc_en      = en;
    bus.br_type    = 3'(bt);
    bus.br_offset  = off_v[OFF_W-1:0];
    bus.flags_we   = fwe;
    bus.flags_in   = 4'(fin);
    taken   = en && cond_true(bt, m_flags);
    if (!en)        n_pc = m_pc;
    else if (taken) n_pc = (((m_pc + 1 + off) % PC_MOD) + PC_MOD) % PC_MOD;
    else            n_pc = (m_pc + 1) % PC_MOD;
    n_flags = fwe ? fin : m_flags;
    n_cnt   = (taken && m_cnt < 255) ? m_cnt + 1 : m_cnt;
    @(posedge clk);
    m_pc    = n_pc;
    m_flags = n_flags;
    m_flush = taken ? 1 : 0;
    m_cnt   = n_cnt;
    #1;
  endtask

  // Reset raised mid-cycle: outputs must clear before any clock edge.
  task automatic async_reset();
    #2;
    reset   = 1'b1;
    m_pc    = 0;
    m_flags = 0;
    m_flush = 0;
    m_cnt   = 0;
    #1;
    chk("async_pc", int'(bus.pc), 0);
    chk("async_flags", int'(bus.flags_q), 0);
    chk("async_flush", int'(bus.flush), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    m_pc    = 0;
    m_flags = 0;
    m_flush = 0;
    m_cnt   = 0;
    reset         = 1'b1;
    bus.pc_en     = 1'b0;
    bus.br_type   = 3'b000;
    bus.br_offset = 8'd0;
    bus.flags_we  = 1'b0;
    bus.flags_in  = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_pc", int'(bus.pc), 0);
    chk("reset_flags", int'(bus.flags_q), 0);

    // Sequential fetch 0,1,2,3.
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 0, 0);
      chk("seq_pc", int'(bus.pc), i);
      chk("seq_flush", int'(bus.flush), 0);
    end

    // Set Z while stalled, then BRE +4 from 3 lands on 8 with a single flush.
    step(0, 0, 0, 1, 4'b0100);
    chk("flag_set", int'(bus.flags_q), 4);
    chk("stall_pc", int'(bus.pc), 3);
    step(1, 2, 4, 0, 0);
    chk("bre_pc", int'(bus.pc), 8);
    chk("bre_flush", int'(bus.flush), 1);
    step(1, 0, 0, 0, 0);
    chk("after_pc", int'(bus.pc), 9);
    chk("after_flush", int'(bus.flush), 0);

    // Same-cycle flag write must not affect that cycle's branch.
    step(0, 0, 0, 1, 4'b0000);
    step(1, 2, 4, 1, 4'b0100);
    chk("samecyc_pc", int'(bus.pc), 10);
    chk("samecyc_flush", int'(bus.flush), 0);
    step(1, 2, 4, 0, 0);
    chk("nextcyc_pc", int'(bus.pc), 15);

    // N=1,V=0: BRGE falls through, BRN taken.
    step(0, 0, 0, 1, 4'b0010);
    step(1, 5, 2, 0, 0);
    chk("brge_nt", int'(bus.pc), 16);
    step(1, 7, 2, 0, 0);
    chk("brn_t", int'(bus.pc), 19);
    // N=1,V=1,Z=0: BRG taken with a negative offset.
    step(0, 0, 0, 1, 4'b0011);
    step(1, 4, -5, 0, 0);
    chk("brg_t", int'(bus.pc), 15);
    step(1, 1, 15, 0, 0);
    chk("jump_31", int'(bus.pc), 31);
    step(1, 1, 0, 0, 0);
    chk("wrap_pc", int'(bus.pc), 0);
    chk("wrap_flush", int'(bus.flush), 1);
    // Self-loop with offset -1, flush held on each taken cycle.
    step(1, 1, -1, 0, 0);
    step(1, 1, -1, 0, 0);
    chk("loop_pc", int'(bus.pc), 0);
    chk("loop_flush", int'(bus.flush), 1);
    step(1, 1, -3, 0, 0);
    chk("negwrap_pc", int'(bus.pc), 30);

    // Carry branch, BRE not taken, BRNE taken, none-type fall through.
    step(0, 0, 0, 1, 4'b1000);
    step(1, 6, 1, 0, 0);
    chk("brc_t", int'(bus.pc), 0);
    step(1, 2, 5, 0, 0);
    chk("bre_nt", int'(bus.pc), 1);
    step(1, 3, 2, 0, 0);
    chk("brne_t", int'(bus.pc), 4);
    step(1, 0, 7, 0, 0);
    chk("none_pc", int'(bus.pc), 5);

    // Stall with JUMP selected: PC holds, no flush.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 9, 0, 0);
      chk("stall_hold", int'(bus.pc), 5);
      chk("stall_flush", int'(bus.flush), 0);
    end
    async_reset();

    // Reset mid-branch discards the pending JUMP; flags restart at zero.
    step(1, 0, 0, 1, 4'b1000);
    bus.pc_en     = 1'b1;
    bus.br_type   = 3'b001;
    bus.br_offset = 8'd10;
    async_reset();
    step(1, 6, 10, 0, 0);
    chk("post_reset_brc", int'(bus.pc), 1);

`ifdef BRANCH_COUNT_EN
    for (int i = 0; i < 260; i++) begin
      step(1, 1, 0, 0, 0);
    end
    chk("cnt_sat", int'(bus.taken_count), 255);
    async_reset();
    chk("cnt_reset", int'(bus.taken_count), 0);
`endif

    step(1, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
